// File: rtl/fifo_umbral_pkg.sv
// Shared default geometry for the threshold FIFO and the control FSM that drives init.
package fifo_umbral_pkg;
  localparam int DATA_WIDTH_DEF = 6;
  localparam int ADDR_WIDTH_DEF = 2;
  localparam int LENGTH_DEF     = 2;
endpackage

// File: rtl/mem_fifo.sv
// FIFO storage: one write port, one registered read port. The array itself is never reset.
module mem_fifo #(
  parameter int DW = 6,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  // Read uses the pre-write contents, so a simultaneous push/pop on the same slot returns the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-empty/almost-full threshold (umbral) and error pulse.
module fifo_umbral
  import fifo_umbral_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LENGTH     = LENGTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init_in,
  input  logic [LENGTH-1:0]     umbral_in,
  input  logic                  push_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty_out,
  output logic                  full_out,
  output logic                  almost_empty_out,
  output logic                  almost_full_out,
  output logic                  error_out
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNTW  = ADDR_WIDTH + 1;
  localparam int CW    = (CNTW > LENGTH) ? CNTW + 1 : LENGTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]       count_q, count_d;
  logic [LENGTH-1:0]     umbral_q, umbral_d;
  logic                  valid_q, error_q, error_d;
  logic                  push_ok, pop_ok;
  logic [CW-1:0]         cnt_x, umb_x, room_x;

  assign empty_out = (count_q == CNTW'(0));
  assign full_out  = (count_q == CNTW'(DEPTH));

  // Full with a concurrent pop still frees a slot this cycle.
  assign pop_ok  = pop_in && !empty_out;
  assign push_ok = push_in && (!full_out || pop_ok);

  // Widen count and threshold to a common size so the compares are unsigned and lossless.
  assign cnt_x  = CW'(count_q);
  assign umb_x  = CW'(umbral_q);
  assign room_x = CW'(DEPTH) - cnt_x;

  assign almost_empty_out = !empty_out && (cnt_x <= umb_x);
  assign almost_full_out  = !full_out && (room_x <= umb_x);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    umbral_d = umbral_q;
    error_d  = (push_in && !push_ok) || (pop_in && !pop_ok);
    if (init_in) umbral_d = umbral_in;
    if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      umbral_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      umbral_q <= umbral_d;
      valid_q  <= pop_ok;
      error_q  <= error_d;
    end
  end

  mem_fifo #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_mem (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (push_ok),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in),
    .rd_en_i   (pop_ok),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (data_out)
  );

  assign valid_out = valid_q;
  assign error_out = error_q;
endmodule

// File: tb/tb_fifo_umbral.sv
// Directed bench for fifo_umbral: expected read words queued at pop time, checked by a negedge monitor.
module tb_fifo_umbral;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init_in = 1'b0;
  logic [1:0] umbral_in = '0;
  logic       push_in = 1'b0;
  logic [5:0] data_in = '0;
  logic       pop_in = 1'b0;
  logic [5:0] data_out;
  logic       valid_out, empty_out, full_out, almost_empty_out, almost_full_out, error_out;

  int total = 0;
  int bad = 0;
  logic [5:0] exp_q[$];

  fifo_umbral dut (
    .clk(clk), .reset(reset), .init_in(init_in), .umbral_in(umbral_in),
    .push_in(push_in), .data_in(data_in), .pop_in(pop_in),
    .data_out(data_out), .valid_out(valid_out), .empty_out(empty_out),
    .full_out(full_out), .almost_empty_out(almost_empty_out),
    .almost_full_out(almost_full_out), .error_out(error_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Flags as {empty, full, almost_empty, almost_full, error}
  task automatic chk_flags(input string name, input logic [4:0] exp);
    chk(name, {27'd0, empty_out, full_out, almost_empty_out, almost_full_out, error_out}, {27'd0, exp});
  endtask

  // One clock of stimulus; returns at posedge+1. exp_rd queued when the pop is expected to be accepted.
  task automatic step(input logic push, input logic [5:0] d, input logic pop,
                      input logic exp_acc, input logic [5:0] exp_rd);
    push_in = push; data_in = d; pop_in = pop;
    if (exp_acc) exp_q.push_back(exp_rd);
    @(posedge clk); #1;
    push_in = 1'b0; pop_in = 1'b0;
  endtask

  task automatic load_umbral(input logic [1:0] u);
    init_in = 1'b1; umbral_in = u;
    @(posedge clk); #1;
    init_in = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && valid_out) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid: got data %0h want no valid", data_out);
      end else begin
        chk("read_data", {26'd0, data_out}, {26'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_flags("reset_flags", 5'b10000);
    chk("reset_valid", {31'd0, valid_out}, 32'd0);
    chk("reset_data", {26'd0, data_out}, 32'd0);
    reset = 1'b0;

    // Fill with threshold 1
    load_umbral(2'd1);
    chk_flags("after_init", 5'b10000);
    step(1, 6'h01, 0, 0, 0); chk_flags("push1", 5'b00100);
    step(1, 6'h02, 0, 0, 0); chk_flags("push2", 5'b00000);
    step(1, 6'h03, 0, 0, 0); chk_flags("push3", 5'b00010);
    step(1, 6'h04, 0, 0, 0); chk_flags("push4_full", 5'b01000);

    // Overflow attempt
    step(1, 6'h05, 0, 0, 0); chk_flags("overflow_err", 5'b01001);
    step(0, 6'h00, 0, 0, 0); chk_flags("err_one_cycle", 5'b01000);

    // Drain
    step(0, 0, 1, 1, 6'h01); chk("pop1_valid", {31'd0, valid_out}, 32'd1);
    chk_flags("pop1_flags", 5'b00010);
    step(0, 0, 1, 1, 6'h02);
    step(0, 0, 1, 1, 6'h03); chk_flags("pop3_flags", 5'b00100);
    step(0, 0, 1, 1, 6'h04); chk_flags("drained", 5'b10000);
    step(0, 0, 0, 0, 0);     chk("idle_valid", {31'd0, valid_out}, 32'd0);
    chk("idle_hold_data", {26'd0, data_out}, 32'h04);

    // Push+pop on empty: push taken, pop rejected
    step(1, 6'h11, 1, 0, 0); chk_flags("empty_pushpop", 5'b00101);
    chk("empty_pushpop_valid", {31'd0, valid_out}, 32'd0);
    step(0, 0, 1, 1, 6'h11); chk_flags("empty_pushpop_drain", 5'b10000);

    // Underflow attempt
    step(0, 0, 1, 0, 0);     chk_flags("underflow_err", 5'b10001);

    // Wrap: pointers now at 1
    step(1, 6'h21, 0, 0, 0);
    step(1, 6'h22, 0, 0, 0);
    step(1, 6'h23, 0, 0, 0);
    step(1, 6'h24, 0, 0, 0); chk_flags("wrap_full", 5'b01000);
    step(1, 6'h2A, 1, 1, 6'h21); chk_flags("full_pushpop", 5'b01000);
    step(0, 0, 1, 1, 6'h22);
    step(0, 0, 1, 1, 6'h23);
    step(0, 0, 1, 1, 6'h24);
    step(0, 0, 1, 1, 6'h2A); chk_flags("wrap_drained", 5'b10000);

    // Async reset with 2 stored words and valid high
    step(1, 6'h31, 0, 0, 0);
    step(1, 6'h32, 0, 0, 0);
    step(1, 6'h33, 1, 1, 6'h31);
    @(negedge clk); #2;
    chk("pre_reset_valid", {31'd0, valid_out}, 32'd1);
    reset = 1'b1; #1;
    chk_flags("async_reset_flags", 5'b10000);
    chk("async_reset_valid", {31'd0, valid_out}, 32'd0);
    chk("async_reset_data", {26'd0, data_out}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // First edge after reset; threshold cleared so almost flags stay low
    step(1, 6'h3C, 0, 0, 0); chk_flags("post_reset_push", 5'b00000);
    step(0, 0, 1, 1, 6'h3C); chk_flags("post_reset_pop", 5'b10000);

    // Threshold 0 disables almost flags across the fill
    load_umbral(2'd0);
    step(1, 6'h01, 0, 0, 0); chk_flags("u0_c1", 5'b00000);
    step(1, 6'h02, 0, 0, 0); chk_flags("u0_c2", 5'b00000);
    step(1, 6'h03, 0, 0, 0); chk_flags("u0_c3", 5'b00000);
    step(1, 6'h04, 0, 0, 0); chk_flags("u0_c4", 5'b01000);

    // Threshold 3 while full: init leaves contents untouched
    load_umbral(2'd3);
    chk_flags("u3_full", 5'b01000);
    step(0, 0, 1, 1, 6'h01); chk_flags("u3_c3", 5'b00110);
    step(0, 0, 1, 1, 6'h02);
    step(0, 0, 1, 1, 6'h03);
    step(0, 0, 1, 1, 6'h04); chk_flags("u3_empty", 5'b10000);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
